// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// parking_gate_arbiter: shared-lane barrier arbiter (entry/exit, full-lot, timeout)
// Option macro GATE_EXIT_PRIORITY_EN: exit wins every tie, no round-robin pointer.
// Revision: 1.0
// ============================================================================
module parking_gate_arbiter #(
  parameter int CAPACITY       = 99,
  parameter int CNT_W          = 7,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 50
) (
  input  logic             clk,
  input  logic             btnC,
  input  logic             req_in,
  input  logic             req_out,
  input  logic [CNT_W-1:0] count,
  input  logic             entering,
  input  logic             exiting,
  output logic             gate_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic             full,
  output logic             timeout_err
);

  localparam int TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  // The IDLE arbitration cycle counts toward the closed gap, so CLOSING is one shorter.
  localparam logic [TW-1:0] HOLD_LAST = TW'((HOLD_CYCLES >= 2) ? (HOLD_CYCLES - 2) : 0);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] OPEN_IN  = 2'd1;
  localparam logic [1:0] OPEN_OUT = 2'd2;
  localparam logic [1:0] CLOSING  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tmo_hit_q, tmo_hit_d;
  logic          gate_open_q, gate_open_d;
  logic          grant_in_q, grant_in_d;
  logic          grant_out_q, grant_out_d;
  logic          full_q, full_d;
  logic          timeout_err_q, timeout_err_d;
  logic          in_ok, out_ok, in_wins_tie;
  logic [31:0]   count_ext;

  assign count_ext = 32'(count);
  assign in_ok     = req_in & ~full_q;
  assign out_ok    = req_out;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    tmo_hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (in_ok && (!out_ok || in_wins_tie)) begin
          state_d = OPEN_IN;
        end else if (out_ok) begin
          state_d = OPEN_OUT;
        end
      end
      OPEN_IN: begin
        if (entering) begin
          state_d = CLOSING;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d   = CLOSING;
          timer_d   = '0;
          tmo_hit_d = 1'b1;
        end
      end
      OPEN_OUT: begin
        if (exiting) begin
          state_d = CLOSING;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d   = CLOSING;
          timer_d   = '0;
          tmo_hit_d = 1'b1;
        end
      end
      CLOSING: begin
        if (timer_q >= HOLD_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

`ifdef GATE_EXIT_PRIORITY_EN
  assign in_wins_tie = 1'b0;
`else
  logic prefer_in_q, prefer_in_d;

  // Pointer names the direction that wins the next tie: opposite of the last grant.
  always_comb begin
    prefer_in_d = prefer_in_q;
    if (state_q == IDLE && state_d == OPEN_IN) begin
      prefer_in_d = 1'b0;
    end else if (state_q == IDLE && state_d == OPEN_OUT) begin
      prefer_in_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      prefer_in_q <= 1'b1;
    end else begin
      prefer_in_q <= prefer_in_d;
    end
  end

  assign in_wins_tie = prefer_in_q;
`endif

  always_comb begin
    gate_open_d   = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
    grant_in_d    = (state_q == OPEN_IN);
    grant_out_d   = (state_q == OPEN_OUT);
    full_d        = (count_ext >= 32'(CAPACITY));
    timeout_err_d = tmo_hit_q;
  end

  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      tmo_hit_q     <= 1'b0;
      gate_open_q   <= 1'b0;
      grant_in_q    <= 1'b0;
      grant_out_q   <= 1'b0;
      full_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      tmo_hit_q     <= tmo_hit_d;
      gate_open_q   <= gate_open_d;
      grant_in_q    <= grant_in_d;
      grant_out_q   <= grant_out_d;
      full_q        <= full_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign grant_in    = grant_in_q;
  assign grant_out   = grant_out_q;
  assign full        = full_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// Scoreboard bench for parking_gate_arbiter: stimulus queues expected output events
// (grant rises, gate falls with timeout flag) stamped with the cycle they must appear.
module tb_parking_gate_arbiter;
  localparam int CAPACITY       = 3;
  localparam int CNT_W          = 7;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int HOLD_CYCLES    = 4;

  localparam int EV_GIN  = 1;
  localparam int EV_GOUT = 2;
  localparam int EV_FALL = 3;
  localparam int EV_TMO  = 4;

`ifdef GATE_EXIT_PRIORITY_EN
  localparam bit EXIT_PRIO = 1'b1;
`else
  localparam bit EXIT_PRIO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             btnC, req_in, req_out, entering, exiting;
  logic [CNT_W-1:0] count;
  logic             gate_open, grant_in, grant_out, full, timeout_err;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   kind;
    int   stamp;
    logic tmo;
  } ev_t;
  ev_t exp_q[$];

  parking_gate_arbiter #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .btnC(btnC), .req_in(req_in), .req_out(req_out), .count(count),
    .entering(entering), .exiting(exiting), .gate_open(gate_open),
    .grant_in(grant_in), .grant_out(grant_out), .full(full), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int stamp, input logic tmo);
    ev_t e;
    e.kind  = kind;
    e.stamp = stamp;
    e.tmo   = tmo;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic tmo);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d tmo %0b at cycle %0d, expected none", kind, tmo, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.stamp != cyc || e.tmo !== tmo) begin
        failures++;
        $display("FAIL event: got kind %0d cycle %0d tmo %0b, expected kind %0d cycle %0d tmo %0b",
                 kind, cyc, tmo, e.kind, e.stamp, e.tmo);
      end
    end
  endtask

  // Monitor: edge-detects outputs at the falling clock edge; silent while reset is held.
  logic prev_gate = 1'b0, prev_gi = 1'b0, prev_go = 1'b0;
  always @(negedge clk) begin
    if (btnC !== 1'b1) begin
      prev_gate = 1'b0;
      prev_gi   = 1'b0;
      prev_go   = 1'b0;
    end else begin
      if (grant_in && !prev_gi)   observe(EV_GIN, 1'b0);
      if (grant_out && !prev_go)  observe(EV_GOUT, 1'b0);
      if (!gate_open && prev_gate) observe(EV_FALL, timeout_err);
      else if (timeout_err)        observe(EV_TMO, 1'b1);
      prev_gate = gate_open;
      prev_gi   = grant_in;
      prev_go   = grant_out;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // An input driven at the falling edge of cycle c is sampled at edge c+1;
  // the registered outputs then show the response after edge c+2.
  initial begin
    int d, x, g;
    bit dir_out;
    btnC = 1'b0; req_in = 1'b0; req_out = 1'b0; count = '0;
    entering = 1'b0; exiting = 1'b0;

    // Reset
    step(5);
    check("reset_gate_open", gate_open, 0);
    check("reset_grant_in", grant_in, 0);
    check("reset_grant_out", grant_out, 0);
    check("reset_full", full, 0);
    check("reset_timeout_err", timeout_err, 0);
    btnC = 1'b1;
    step(1);

    // First entry grant and normal passage
    d = cyc; req_in = 1'b1;
    expect_ev(EV_GIN, d + 2, 1'b0);
    step(2);
    check("grant_latency_grant_in", grant_in, 1);
    check("grant_latency_gate_open", gate_open, 1);
    req_in = 1'b0;
    step(4);
    x = cyc; entering = 1'b1;
    expect_ev(EV_FALL, x + 2, 1'b0);
    step(1); entering = 1'b0;
    step(1);
    check("passage_gate_low", gate_open, 0);
    // Re-request immediately: the gap must be exactly HOLD_CYCLES closed cycles
    req_in = 1'b1;
    expect_ev(EV_GIN, x + 6, 1'b0);
    step(4);

    // Timeout: no passage, gate open for exactly TIMEOUT_CYCLES, one error pulse
    req_in = 1'b0; g = cyc;
    expect_ev(EV_FALL, g + TIMEOUT_CYCLES, 1'b1);
    step(24);

    // Pulse in the last cycle of the open state beats the timeout
    d = cyc; req_in = 1'b1;
    expect_ev(EV_GIN, d + 2, 1'b0);
    step(2); req_in = 1'b0; g = cyc;
    expect_ev(EV_FALL, g + TIMEOUT_CYCLES, 1'b0);
    step(TIMEOUT_CYCLES - 2); entering = 1'b1;
    step(1); entering = 1'b0;
    step(10);

    // Wrong-direction pulse is ignored; reset mid-window drops the gate at once
    d = cyc; req_in = 1'b1;
    expect_ev(EV_GIN, d + 2, 1'b0);
    step(2); req_in = 1'b0;
    step(2); exiting = 1'b1;
    step(1); exiting = 1'b0;
    step(3);
    check("wrong_dir_gate_open", gate_open, 1);
    #1 btnC = 1'b0;
    #1 check("reset_async_gate_open", gate_open, 0);
    check("reset_async_grant_in", grant_in, 0);
    step(3); btnC = 1'b1;
    step(1);
    d = cyc; req_out = 1'b1;
    expect_ev(EV_GOUT, d + 2, 1'b0);
    step(2); req_out = 1'b0;
    step(1); x = cyc; exiting = 1'b1;
    expect_ev(EV_FALL, x + 2, 1'b0);
    step(1); exiting = 1'b0;
    step(8);

    // Full lot: entry refused, exit still served
    count = CNT_W'(CAPACITY);
    step(2);
    check("full_flag_set", full, 1);
    req_in = 1'b1;
    step(50);
    check("full_gate_closed", gate_open, 0);
    check("full_no_grant_in", grant_in, 0);
    d = cyc; req_out = 1'b1;
    expect_ev(EV_GOUT, d + 2, 1'b0);
    step(2); req_out = 1'b0;
    step(1); x = cyc; exiting = 1'b1;
    expect_ev(EV_FALL, x + 2, 1'b0);
    step(1); exiting = 1'b0; req_in = 1'b0; count = '0;
    step(8);
    check("full_flag_clear", full, 0);

    // Round-robin with both requests held; last grant was exit, so entry goes first
    d = cyc; req_in = 1'b1; req_out = 1'b1; g = d + 2;
    for (int i = 0; i < 4; i++) begin
      dir_out = EXIT_PRIO || (i % 2 == 1);
      expect_ev(dir_out ? EV_GOUT : EV_GIN, g, 1'b0);
      step(g + 2 - cyc);
      if (dir_out) exiting = 1'b1;
      else         entering = 1'b1;
      expect_ev(EV_FALL, g + 4, 1'b0);
      step(1); entering = 1'b0; exiting = 1'b0;
      if (i == 3) begin
        req_in = 1'b0; req_out = 1'b0;
      end
      g = g + 8;
    end
    step(12);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
